// File: rtl/dcache_access_seq.sv
// Dcache access sequencer: splits line-crossing loads/stores into two
// line beats and merges read bytes into one little-endian result.
module dcache_access_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_wr,
  input  logic [63:0]       req_wdata,
  output logic              cache_req,
  output logic [ADDR_W-5:0] cache_line,
  output logic              cache_wr,
  output logic [15:0]       cache_be,
  output logic [127:0]      cache_wdata,
  input  logic              cache_ack,
  input  logic [127:0]      cache_rdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_split
);

  localparam int LW = ADDR_W - 4;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic              wr_r;
  logic [63:0]       wdata_r;
  logic              split_r;
  logic [63:0]       merge_r, merge_nxt;
  logic              split_req;
  logic [3:0]        off;
  logic [4:0]        n, n1, n2;
  logic              busy;
  logic              accept;

  assign off    = addr_r[3:0];
  assign n      = 5'd1 << size_r;
  assign n1     = split_r ? 5'd16 - {1'b0, off} : n;
  assign n2     = n - n1;
  assign busy   = (state == ACC1) || (state == ACC2);
  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    split_req = 1'b0;
    unique case (req_size)
      2'b00:   split_req = 1'b0;
      2'b01:   split_req = req_addr[3:0] == 4'd15;
      2'b10:   split_req = req_addr[3:0] > 4'd12;
      default: split_req = req_addr[3:0] > 4'd8;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = ACC1;
      ACC1:    if (cache_ack) state_nxt = split_r ? ACC2 : DONE;
      ACC2:    if (cache_ack) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line-side steering: byte b of the line maps to request byte k
  logic [3:0] k;
  logic [4:0] bb;

  always_comb begin
    cache_req   = 1'b0;
    cache_line  = '0;
    cache_wr    = 1'b0;
    cache_be    = '0;
    cache_wdata = '0;
    k           = '0;
    bb          = '0;
    if (busy) begin
      cache_req  = 1'b1;
      cache_wr   = wr_r;
      cache_line = addr_r[ADDR_W-1:4];
      if (state == ACC2) cache_line = addr_r[ADDR_W-1:4] + LW'(1);
      for (int b = 0; b < 16; b++) begin
        bb = 5'(b);
        if (state == ACC1) begin
          k = 4'(b) - off;
          if (bb >= {1'b0, off} && bb < {1'b0, off} + n1) begin
            cache_be[b] = 1'b1;
            cache_wdata[b*8 +: 8] = wdata_r[{k[2:0], 3'b000} +: 8];
          end
        end else begin
          k = 4'(b) + n1[3:0];
          if (bb < n2) begin
            cache_be[b] = 1'b1;
            cache_wdata[b*8 +: 8] = wdata_r[{k[2:0], 3'b000} +: 8];
          end
        end
      end
    end
  end

  logic [3:0] k1, k2;

  always_comb begin
    merge_nxt = merge_r;
    k1        = '0;
    k2        = '0;
    if (cache_ack && !wr_r) begin
      for (int i = 0; i < 8; i++) begin
        if (state == ACC1 && 5'(i) < n1) begin
          k1 = off + 4'(i);
          merge_nxt[i*8 +: 8] = cache_rdata[{k1, 3'b000} +: 8];
        end
        if (state == ACC2 && 5'(i) < n2) begin
          k2 = n1[3:0] + 4'(i);
          merge_nxt[{k2[2:0], 3'b000} +: 8] = cache_rdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_r  <= '0;
      size_r  <= '0;
      wr_r    <= 1'b0;
      wdata_r <= '0;
      split_r <= 1'b0;
      merge_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_r  <= req_addr;
        size_r  <= req_size;
        wr_r    <= req_wr;
        wdata_r <= req_wdata;
        split_r <= split_req;
        merge_r <= '0;
      end else begin
        merge_r <= merge_nxt;
      end
    end
  end

  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign rsp_rdata = merge_r;
  assign rsp_split = split_r;

endmodule

// File: tb/tb_dcache_access_seq.sv
// Directed bench for dcache_access_seq with a byte-level memory model
// and a per-cycle output compare.
module tb_dcache_access_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [1:0]   req_size;
  logic         req_wr;
  logic [63:0]  req_wdata;
  logic         cache_req;
  logic [27:0]  cache_line;
  logic         cache_wr;
  logic [15:0]  cache_be;
  logic [127:0] cache_wdata;
  logic         cache_ack;
  logic [127:0] cache_rdata;
  logic         rsp_valid;
  logic [63:0]  rsp_rdata;
  logic         rsp_split;

  dcache_access_seq #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size),
    .req_wr(req_wr), .req_wdata(req_wdata),
    .cache_req(cache_req), .cache_line(cache_line),
    .cache_wr(cache_wr), .cache_be(cache_be),
    .cache_wdata(cache_wdata), .cache_ack(cache_ack),
    .cache_rdata(cache_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_split(rsp_split)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Byte-addressed backing store; unset bytes follow a fixed pattern
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[11:4] ^ 8'h5A;
  endfunction

  function automatic logic [127:0] line_data(input logic [27:0] ln);
    logic [127:0] d;
    d = '0;
    for (int b = 0; b < 16; b++) d[b*8 +: 8] = mem_byte({ln, 4'(b)});
    return d;
  endfunction

  logic [27:0]  m_line1, m_line2;
  logic [15:0]  m_be1, m_be2;
  logic [127:0] m_wd1, m_wd2;
  logic [63:0]  m_rd;
  logic         m_split;

  function automatic void model(input logic [31:0] a, input logic [1:0] sz,
                                input logic wr, input logic [63:0] wd);
    int nb;
    logic [31:0] b;
    nb = 1 << sz;
    m_line1 = a[31:4];
    m_line2 = a[31:4] + 28'd1;
    m_be1 = '0; m_be2 = '0; m_wd1 = '0; m_wd2 = '0;
    m_rd = '0; m_split = 1'b0;
    for (int i = 0; i < nb; i++) begin
      b = a + 32'(i);
      if (b[31:4] == m_line1) begin
        m_be1[b[3:0]] = 1'b1;
        m_wd1[{b[3:0], 3'b000} +: 8] = wd[i*8 +: 8];
      end else begin
        m_split = 1'b1;
        m_be2[b[3:0]] = 1'b1;
        m_wd2[{b[3:0], 3'b000} +: 8] = wd[i*8 +: 8];
      end
      if (!wr) m_rd[i*8 +: 8] = mem_byte(b);
    end
  endfunction

  logic         chk_on = 1'b0;
  logic         exp_ready, exp_req, exp_wr, exp_rv, exp_split;
  logic [27:0]  exp_line;
  logic [15:0]  exp_be;
  logic [127:0] exp_wd;
  logic [63:0]  exp_rdata;

  task automatic exp_idle();
    exp_ready = 1'b1; exp_req = 1'b0; exp_wr = 1'b0; exp_rv = 1'b0;
    exp_line = '0; exp_be = '0; exp_wd = '0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("req_ready", 128'(req_ready), 128'(exp_ready));
      cmp("cache_req", 128'(cache_req), 128'(exp_req));
      cmp("cache_line", 128'(cache_line), 128'(exp_line));
      cmp("cache_wr", 128'(cache_wr), 128'(exp_wr));
      cmp("cache_be", 128'(cache_be), 128'(exp_be));
      cmp("cache_wdata", cache_wdata, exp_wd);
      cmp("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
      if (exp_ready || exp_rv) begin
        cmp("rsp_rdata", 128'(rsp_rdata), 128'(exp_rdata));
        cmp("rsp_split", 128'(rsp_split), 128'(exp_split));
      end
    end
  end

  logic [27:0]  cap_line1, cap_line2;
  logic [15:0]  cap_be1, cap_be2;
  logic [127:0] cap_wd1, cap_wd2;
  logic [63:0]  cap_rd;
  logic         cap_split;

  task automatic beat(input logic [27:0] ln, input logic [15:0] be,
                      input logic [127:0] wd, input logic wr,
                      input int dly, input logic pulse, input logic second);
    for (int c = 0; c <= dly; c++) begin
      cache_ack   = (c == dly);
      cache_rdata = line_data(ln);
      if (pulse) begin
        req_valid = 1'b1;
        req_addr  = $urandom;
      end
      exp_ready = 1'b0; exp_req = 1'b1; exp_rv = 1'b0;
      exp_line = ln; exp_be = be; exp_wd = wd; exp_wr = wr;
      if (c == dly) begin
        #1;
        if (second) begin
          cap_line2 = cache_line; cap_be2 = cache_be; cap_wd2 = cache_wdata;
        end else begin
          cap_line1 = cache_line; cap_be1 = cache_be; cap_wd1 = cache_wdata;
        end
      end
      @(posedge clk); #1;
    end
    cache_ack = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [1:0] sz,
                     input logic wr, input logic [63:0] wd,
                     input int dly, input logic pulse, input logic iack);
    model(a, sz, wr, wd);
    cap_line2 = '0; cap_be2 = '0; cap_wd2 = '0;
    req_valid = 1'b1; req_addr = a; req_size = sz;
    req_wr = wr; req_wdata = wd;
    cache_ack = iack;
    exp_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    cache_ack = 1'b0;
    beat(m_line1, m_be1, m_wd1, wr, dly, pulse, 1'b0);
    if (m_split) beat(m_line2, m_be2, m_wd2, wr, dly, pulse, 1'b1);
    exp_ready = 1'b0; exp_req = 1'b0; exp_line = '0; exp_be = '0;
    exp_wd = '0; exp_wr = 1'b0; exp_rv = 1'b1;
    exp_rdata = m_rd; exp_split = m_split;
    #1;
    cap_rd = rsp_rdata; cap_split = rsp_split;
    @(posedge clk); #1;
    exp_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_size = '0;
    req_wr = 1'b0; req_wdata = '0;
    cache_ack = 1'b0; cache_rdata = '0;
    exp_idle();
    exp_rdata = '0; exp_split = 1'b0;
    mem[32'h1004] = 8'h11; mem[32'h1005] = 8'h22;
    mem[32'h1006] = 8'h33; mem[32'h1007] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      mem[32'h200C + 32'(i)] = 8'hA0 + 8'(i);
      mem[32'h2010 + 32'(i)] = 8'hB0 + 8'(i);
    end
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run(32'h1004, 2'b10, 1'b0, 64'h0, 0, 1'b0, 1'b0);
    cmp("t1_line", 128'(cap_line1), 128'h100);
    cmp("t1_be", 128'(cap_be1), 128'h00F0);
    cmp("t1_rdata", 128'(cap_rd), 128'h44332211);
    cmp("t1_split", 128'(cap_split), 128'h0);

    run(32'h200C, 2'b11, 1'b0, 64'h0, 0, 1'b0, 1'b0);
    cmp("t2_be1", 128'(cap_be1), 128'hF000);
    cmp("t2_line2", 128'(cap_line2), 128'h201);
    cmp("t2_be2", 128'(cap_be2), 128'h000F);
    cmp("t2_rdata", 128'(cap_rd), 128'hB3B2B1B0A3A2A1A0);
    cmp("t2_split", 128'(cap_split), 128'h1);

    run(32'h0000000F, 2'b01, 1'b1, 64'hBEEF, 0, 1'b0, 1'b0);
    cmp("t3_be1", 128'(cap_be1), 128'h8000);
    cmp("t3_wd1", cap_wd1, {8'hEF, 120'h0});
    cmp("t3_line2", 128'(cap_line2), 128'h1);
    cmp("t3_be2", 128'(cap_be2), 128'h0001);
    cmp("t3_wd2", cap_wd2, 128'hBE);
    cmp("t3_rdata", 128'(cap_rd), 128'h0);

    run(32'h0000300C, 2'b10, 1'b0, 64'h0, 0, 1'b0, 1'b0);
    cmp("off12_w_split", 128'(cap_split), 128'h0);
    cmp("off12_w_be", 128'(cap_be1), 128'hF000);

    run(32'h0000300E, 2'b01, 1'b1, 64'h1234, 0, 1'b0, 1'b0);
    cmp("off14_h_split", 128'(cap_split), 128'h0);

    run(32'h00003009, 2'b11, 1'b0, 64'h0, 0, 1'b0, 1'b0);
    cmp("off9_d_be1", 128'(cap_be1), 128'hFE00);
    cmp("off9_d_be2", 128'(cap_be2), 128'h0001);
    cmp("off9_d_split", 128'(cap_split), 128'h1);

    run(32'hFFFFFFFC, 2'b10, 1'b0, 64'h0, 0, 1'b0, 1'b0);
    cmp("top_nosplit", 128'(cap_split), 128'h0);
    cmp("top_line", 128'(cap_line1), 128'hFFFFFFF);

    run(32'hFFFFFFFE, 2'b10, 1'b1, 64'hCAFEF00D, 0, 1'b0, 1'b0);
    cmp("wrap_split", 128'(cap_split), 128'h1);
    cmp("wrap_line2", 128'(cap_line2), 128'h0);
    cmp("wrap_be1", 128'(cap_be1), 128'hC000);
    cmp("wrap_be2", 128'(cap_be2), 128'h0003);

    run(32'h00005ABC, 2'b11, 1'b1, 64'h8877665544332211, 3, 1'b1, 1'b0);
    cmp("slow_wd2", cap_wd2, 128'h88776655);

    run(32'h0000600F, 2'b00, 1'b0, 64'h0, 2, 1'b0, 1'b1);

    // Reset while the second beat is waiting for ack
    model(32'h00007FFE, 2'b10, 1'b0, 64'h0);
    req_valid = 1'b1; req_addr = 32'h00007FFE; req_size = 2'b10;
    req_wr = 1'b0; req_wdata = '0;
    exp_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    beat(m_line1, m_be1, m_wd1, 1'b0, 0, 1'b0, 1'b0);
    cache_rdata = line_data(m_line2);
    exp_ready = 1'b0; exp_req = 1'b1; exp_line = m_line2;
    exp_be = m_be2; exp_wd = m_wd2; exp_wr = 1'b0; exp_rv = 1'b0;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    exp_idle();
    exp_rdata = '0; exp_split = 1'b0;
    #1;
    cmp("rst_cache_req", 128'(cache_req), 128'h0);
    cmp("rst_req_ready", 128'(req_ready), 128'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(32'h00001004, 2'b10, 1'b0, 64'h0, 1, 1'b0, 1'b0);
    cmp("post_rst_rdata", 128'(cap_rd), 128'h44332211);

    repeat (2) @(posedge clk);
    #1 chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dcache_access_seq.md
Name: dcache_access_seq

Overview:
Sequencer in front of the dcache data array. It accepts one load or store of 1, 2, 4 or 8 bytes at any byte address. When the access crosses a 16-byte line, it splits the access into two line accesses. Read bytes from both lines are merged into a single little-endian result. Store data and byte enables are steered to each line.

Parameters:
ADDR_W, 32, byte-address width; line index is ADDR_W-4 bits.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  access request
req_ready  out  1  sequencer can accept a request (IDLE only)
req_addr  in  ADDR_W  byte address
req_size  in  2  size code: 00=1B, 01=2B, 10=4B, 11=8B
req_wr  in  1  1=store, 0=load
req_wdata  in  64  store data, little-endian, low bytes valid
cache_req  out  1  line access request to data array
cache_line  out  ADDR_W-4  line index
cache_wr  out  1  line write
cache_be  out  16  byte enables within line
cache_wdata  out  128  line-positioned store data
cache_ack  in  1  data array completed current line access
cache_rdata  in  128  line read data, valid with cache_ack
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  64  load result, zero-extended above size
rsp_split  out  1  completed access used two line accesses

Behaviour:
- Reset values: all outputs are 0, except req_ready=1. The state machine is in IDLE.
- States: IDLE, ACC1, ACC2, DONE.
  - IDLE: req_ready=1.
  - On req_valid, latch addr, size, wr and wdata. Clear the merge register. Go to ACC1.
- Byte count n = 1<<size. Offset off = addr[3:0].
- Split condition, latched at accept, is true for any of:
  - size=01 and off=15
  - size=10 and off>12
  - size=11 and off>8
  - size=00 never splits.
- n1 = split ? 16-off : n. n2 = n-n1.
- ACC1 outputs:
  - cache_req=1, cache_line=addr[ADDR_W-1:4], cache_wr=wr.
  - cache_be bits [off, off+n1-1] set.
  - cache_wdata byte off+i = wdata byte i, for i<n1. All other bytes are 0.
  - Outputs hold stable until cache_ack.
- ACC1 on cache_ack:
  - For a load, merge byte i = cache_rdata byte off+i, for i<n1.
  - Go to ACC2 if split, else DONE.
- ACC2 outputs:
  - cache_line = latched line + 1, modulo 2^(ADDR_W-4). Line index all-ones wraps to 0.
  - cache_be bits [0, n2-1] set.
  - cache_wdata byte j = wdata byte n1+j.
- ACC2 on cache_ack:
  - For a load, merge byte n1+j = cache_rdata byte j, for j<n2.
  - Go to DONE.
- cache_req drops in the cycle after the cache_ack of each access's final beat. It is 0 in DONE.
  - Between ACC1 and ACC2, cache_req stays 1 with the new line and byte enables; there is no idle cycle.
- DONE:
  - rsp_valid=1 for exactly one cycle. rsp_rdata = merge register; bytes >= n are 0.
  - rsp_split = latched split.
  - For stores, rsp_rdata=0.
  - Next state is IDLE.
- rsp_rdata and rsp_split hold their values after DONE until the next accept.
- cache_ack outside ACC1/ACC2 is ignored.
- Latency with zero-wait ack (ack in the first cycle of each access):
  - Non-split: accept at cycle T, rsp_valid at T+2.
  - Split: rsp_valid at T+3.
- A request arriving while not in IDLE is not accepted (req_ready=0). The requester holds req_valid.
- Reset asserted mid-operation: the state machine goes to IDLE immediately and all outputs return to reset values. The in-flight access is abandoned and no rsp_valid is produced.

Test Plan:
- Load size=10, addr=0x1004, ack same cycle. Line 0x100, be=0x00F0. rdata bytes 4..7 = 11 22 33 44. Required: rsp_rdata=0x44332211 at T+2, rsp_split=0.
- Load size=11, addr=0x200C. ACC1: line 0x200, be=0xF000. ACC2: line 0x201, be=0x000F. Bytes 12..15 = A0..A3, next line bytes 0..3 = B0..B3. Required: rsp_rdata=0xB3B2B1B0A3A2A1A0, rsp_split=1 at T+3.
- Store size=01, addr=0x0F, wdata=0xBEEF. ACC1: be=0x8000, byte15=EF. ACC2: line 1, be=0x0001, byte0=BE.
- Boundary checks:
  - size=10 at off=12 does not split.
  - size=01 at off=14 does not split.
  - size=11 at off=9 splits with n1=7, n2=1.
  - addr=0xFFFFFFFC size=10 does not split.
  - addr=0xFFFFFFFE size=10 splits, and the second line wraps to 0.
- cache_ack delayed 3 cycles in each access: outputs are stable and req_ready=0 throughout. req_valid pulsed during the busy window is not accepted. Exactly one rsp_valid.
- rst_n asserted while in ACC2 with cache_ack low: cache_req=0 and req_ready=1 in the same cycle. No rsp_valid. The next request completes normally.
